// File: rtl/xsw_port_drain.sv
// Drains one switch output port into a small local FIFO. Each word is read
// with an IDLE/REQ/CAPT sequence, and words tagged for another port are counted as misroutes.
module xsw_port_drain #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              data_rdy,
    output logic              rd_en,
    input  logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W-1:0] addr_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              clr_cnt,
    output logic [15:0]       pkt_cnt,
    output logic [7:0]        err_cnt,
    output logic              err_flag,
    output logic [1:0]        state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(PORT_ID);
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop, miss;

    // Sink handshake: a word moves on any edge where m_valid && m_ready;
    // m_valid never depends on m_ready and m_data holds until that edge.
    assign m_valid   = (count != '0);
    assign m_data    = mem[rd_ptr];
    assign pop       = m_valid && m_ready;
    assign push      = (state == CAPT) && (addr_out == MY_ADDR);
    assign miss      = (state == CAPT) && (addr_out != MY_ADDR);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en && data_rdy && (count < FULL_CNT)) state_next = REQ;
            REQ:  state_next = CAPT;
            CAPT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rd_en <= 1'b0;
        end else begin
            state <= state_next;
            rd_en <= (state_next == REQ);
        end
    end

    // Only one read is ever outstanding, so a push can never hit a full buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (clr_cnt) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            if (push && (pkt_cnt != 16'hFFFF)) pkt_cnt <= pkt_cnt + 16'd1;
            if (miss && (err_cnt != 8'hFF))    err_cnt <= err_cnt + 8'd1;
            if (miss)                          err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xsw_port_drain.sv
// Directed bench for xsw_port_drain with PORT_ID=2, DEPTH=4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_xsw_port_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        data_rdy = 1'b0;
    logic        rd_en;
    logic [7:0]  data_out = 8'h00;
    logic [7:0]  addr_out = 8'h00;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        clr_cnt = 1'b0;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
    logic        err_flag;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    xsw_port_drain #(.DATA_W(8), .ADDR_W(8), .PORT_ID(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .data_rdy(data_rdy), .rd_en(rd_en),
        .data_out(data_out), .addr_out(addr_out), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .clr_cnt(clr_cnt),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One data_rdy pulse; optionally raise m_ready during CAPT so a pop
    // coincides with the push, or raise clr_cnt during CAPT.
    task automatic read_word(input logic [7:0] d, input logic [7:0] a,
                             input bit pop_in_capt, input bit clr_in_capt);
        data_out = d;
        addr_out = a;
        data_rdy = 1'b1;
        cyc(1);
        data_rdy = 1'b0;
        chk("rd_en_req", rd_en, 1'b1);
        cyc(1);
        chk("rd_en_capt", rd_en, 1'b0);
        if (pop_in_capt) m_ready = 1'b1;
        if (clr_in_capt) clr_cnt = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        clr_cnt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc(2);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 16'h0);
        chk("rst_err_cnt", err_cnt, 8'h0);
        chk("rst_err_flag", err_flag, 1'b0);
        chk("rst_state", state_dbg, 2'd0);
        reset = 1'b1;
        en = 1'b1;
        cyc(1);

        // Single word: m_valid appears three cycles after data_rdy
        data_out = 8'hA5;
        addr_out = 8'h02;
        data_rdy = 1'b1;
        cyc(1);
        data_rdy = 1'b0;
        chk("single_rd_en_1", rd_en, 1'b1);
        chk("single_valid_1", m_valid, 1'b0);
        cyc(1);
        chk("single_rd_en_2", rd_en, 1'b0);
        chk("single_valid_2", m_valid, 1'b0);
        cyc(1);
        chk("single_valid_3", m_valid, 1'b1);
        chk("single_data", m_data, 8'hA5);
        chk("single_pkt_cnt", pkt_cnt, 16'd1);
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        chk("single_popped", m_valid, 1'b0);

        // Misroute, then counter clear
        read_word(8'h11, 8'h03, 1'b0, 1'b0);
        chk("mis_valid", m_valid, 1'b0);
        chk("mis_err_cnt", err_cnt, 8'd1);
        chk("mis_err_flag", err_flag, 1'b1);
        chk("mis_pkt_cnt", pkt_cnt, 16'd1);
        cyc(3);
        chk("mis_flag_sticky", err_flag, 1'b1);
        clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        chk("clr_pkt_cnt", pkt_cnt, 16'd0);
        chk("clr_err_cnt", err_cnt, 8'd0);
        chk("clr_err_flag", err_flag, 1'b0);

        // en low blocks new reads
        en = 1'b0;
        data_rdy = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1);
            if (rd_en) pulses++;
        end
        chk("en_low_no_read", pulses, 0);

        // Backpressure: exactly four reads fill the buffer
        addr_out = 8'h02;
        en = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1);
            if (rd_en) begin
                pulses++;
                data_out = 8'(pulses);
                exp_q.push_back(8'(pulses));
            end
        end
        chk("full_pulses", pulses, 4);
        chk("full_rd_en", rd_en, 1'b0);
        chk("full_valid", m_valid, 1'b1);
        chk("full_head", m_data, 8'd1);

        // Release: 1..4 drain in order, reads resume for 5 and 6
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (m_valid) begin
                if (exp_q.size() > 0) chk("drain_order", m_data, exp_q.pop_front());
                else begin
                    checks++;
                    errors++;
                    $display("FAIL drain_extra observed=%0h expected=none", m_data);
                end
            end
            cyc(1);
            if (rd_en) begin
                pulses++;
                data_out = 8'(pulses);
                exp_q.push_back(8'(pulses));
                if (pulses == 6) data_rdy = 1'b0;
            end
        end
        m_ready = 1'b0;
        chk("drain_total_reads", pulses, 6);
        chk("drain_q_empty", exp_q.size(), 0);
        chk("drain_pkt_cnt", pkt_cnt, 16'd6);

        // Simultaneous push and pop with two words buffered
        read_word(8'h21, 8'h02, 1'b0, 1'b0);
        read_word(8'h22, 8'h02, 1'b0, 1'b0);
        chk("pp_head_before", m_data, 8'h21);
        read_word(8'h23, 8'h02, 1'b1, 1'b0);
        chk("pp_head_after", m_data, 8'h22);
        m_ready = 1'b1;
        cyc(1);
        chk("pp_second", m_data, 8'h23);
        chk("pp_second_valid", m_valid, 1'b1);
        cyc(1);
        chk("pp_empty", m_valid, 1'b0);
        cyc(1);
        m_ready = 1'b0;

        // en falling mid-read lets the read finish
        data_out = 8'h44;
        addr_out = 8'h02;
        data_rdy = 1'b1;
        cyc(1);
        en = 1'b0;
        data_rdy = 1'b0;
        cyc(2);
        chk("en_fall_valid", m_valid, 1'b1);
        chk("en_fall_data", m_data, 8'h44);
        en = 1'b1;

        // Reset during CAPT with a word already buffered
        data_out = 8'h55;
        data_rdy = 1'b1;
        cyc(1);
        data_rdy = 1'b0;
        cyc(1);
        chk("rst_mid_state", state_dbg, 2'd2);
        reset = 1'b0;
        #1;
        chk("rst_mid_rd_en", rd_en, 1'b0);
        chk("rst_mid_valid", m_valid, 1'b0);
        chk("rst_mid_pkt", pkt_cnt, 16'd0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        chk("rst_after_pkt", pkt_cnt, 16'd0);
        chk("rst_after_valid", m_valid, 1'b0);

        // err_cnt saturation after 256 misroutes
        addr_out = 8'h05;
        data_out = 8'h77;
        data_rdy = 1'b1;
        pulses = 0;
        for (int c = 0; c < 1000 && pulses < 256; c++) begin
            cyc(1);
            if (rd_en) pulses++;
            if (pulses == 256) data_rdy = 1'b0;
        end
        chk("sat_reads", pulses, 256);
        cyc(3);
        chk("sat_err_cnt", err_cnt, 8'hFF);
        chk("sat_flag", err_flag, 1'b1);
        read_word(8'h78, 8'h05, 1'b0, 1'b0);
        chk("sat_no_wrap", err_cnt, 8'hFF);
        read_word(8'h79, 8'h05, 1'b0, 1'b1);
        chk("sat_clr_err_cnt", err_cnt, 8'h00);
        chk("sat_clr_flag", err_flag, 1'b0);
        chk("sat_no_valid", m_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
